// File: rtl/operand_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : operand_fetch_pkg
// Description : Shared widths, record types and helpers for the operand-fetch
//               stage. The data/control widths here size the packaged types
//               and must match the DATA_WIDTH / CTRL_WIDTH of the stage.
// Revision    : 1.0 - initial release
// ============================================================================
package operand_fetch_pkg;

   localparam int NUM_REGS   = 32;
   localparam int REG_ADDR_W = $clog2(NUM_REGS);
   localparam int DATA_W     = 32;
   localparam int CTRL_W     = 16;

   // Instruction fields held while the stage waits for register-file data.
   typedef struct packed {
      logic [REG_ADDR_W-1:0] rs1;
      logic [REG_ADDR_W-1:0] rs2;
      logic [REG_ADDR_W-1:0] rd;
      logic [CTRL_W-1:0]     ctrl;
   } fetch_entry_t;

   // Per-operand override: when fwd is set, data replaces register-file data.
   typedef struct packed {
      logic              fwd;
      logic [DATA_W-1:0] data;
   } operand_t;

   // True when the addressed register is the hardwired zero register.
   function automatic logic is_zero_reg(input logic zero_en,
                                        input logic [REG_ADDR_W-1:0] rs);
      return zero_en && (rs == '0);
   endfunction

   // True when a writeback commits to the given register at this edge.
   function automatic logic wb_hit(input logic we,
                                   input logic [REG_ADDR_W-1:0] waddr,
                                   input logic [REG_ADDR_W-1:0] rs);
      return we && (waddr == rs);
   endfunction

endpackage
`default_nettype wire

// File: rtl/operand_bypass.sv
`default_nettype none
// ============================================================================
// Module      : operand_bypass
// Description : One operand's forwarding path. Captures a writeback that
//               lands on the accept edge (the register file returns pre-write
//               data for it), resolves the operand by priority, and latches
//               the resolved value while the owning entry is stalled.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               accept          - entry loads into the A slot this edge
//               stall           - A slot is held this edge
//               in_rs / a_rs    - incoming / held source address
//               wb_*            - register-file write port (observed)
//               rf_rdata        - read data for the held address
//               resolved        - fully forwarded operand (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module operand_bypass
   import operand_fetch_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_W,
   parameter bit ZERO_REG   = 1'b1
)
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  accept,
   input  logic                  stall,
   input  logic [REG_ADDR_W-1:0] in_rs,
   input  logic [REG_ADDR_W-1:0] a_rs,
   input  logic                  wb_we,
   input  logic [REG_ADDR_W-1:0] wb_waddr,
   input  logic [DATA_WIDTH-1:0] wb_wdata,
   input  logic [DATA_WIDTH-1:0] rf_rdata,
   output logic [DATA_WIDTH-1:0] resolved
);

   operand_t r_opnd;
   logic     w_in_capture;
   logic     w_a_zero;
   logic     w_a_wb_hit;

   // The zero register is never forwarded, so a write to it is not captured.
   assign w_in_capture = wb_hit(wb_we, wb_waddr, in_rs) && !is_zero_reg(ZERO_REG, in_rs);
   assign w_a_zero     = is_zero_reg(ZERO_REG, a_rs);
   assign w_a_wb_hit   = wb_hit(wb_we, wb_waddr, a_rs);

   // Newest information wins: a write committing this cycle beats an older
   // captured value, which beats the register file's (possibly stale) data.
   always_comb begin
      resolved = rf_rdata;
      if (w_a_zero) begin
         resolved = '0;
      end else if (w_a_wb_hit) begin
         resolved = wb_wdata;
      end else if (r_opnd.fwd) begin
         resolved = r_opnd.data;
      end
   end

   // rf_rdata is only meaningful in A's first cycle, so any stall freezes the
   // resolved value into the override register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_opnd <= '0;
      end else if (accept) begin
         r_opnd.fwd  <= w_in_capture;
         r_opnd.data <= wb_wdata;
      end else if (stall) begin
         r_opnd.fwd  <= 1'b1;
         r_opnd.data <= resolved;
      end
   end

endmodule
`default_nettype wire

// File: rtl/operand_fetch.sv
`default_nettype none
// ============================================================================
// Module      : operand_fetch
// Description : Operand-fetch stage ahead of the register file. Slot A waits
//               one cycle for read data while forwarding writebacks; slot O
//               is the registered output toward execute.
// Ports       : clk, rst, flush              - clock, sync reset, kill
//               in_valid/in_ready, in_rs1/2, in_rd, in_ctrl - upstream
//               rf_raddr1/2, rf_rdata1/2     - register-file read ports
//               wb_we, wb_waddr, wb_wdata    - register-file write port
//               out_valid/out_ready, out_op1/2, out_rd, out_ctrl - execute
// Revision    : 1.0 - initial release
// ============================================================================
module operand_fetch
   import operand_fetch_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_W,
   parameter int CTRL_WIDTH = CTRL_W,
   parameter bit ZERO_REG   = 1'b1
)
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [REG_ADDR_W-1:0] in_rs1,
   input  logic [REG_ADDR_W-1:0] in_rs2,
   input  logic [REG_ADDR_W-1:0] in_rd,
   input  logic [CTRL_WIDTH-1:0] in_ctrl,
   output logic [REG_ADDR_W-1:0] rf_raddr1,
   output logic [REG_ADDR_W-1:0] rf_raddr2,
   input  logic [DATA_WIDTH-1:0] rf_rdata1,
   input  logic [DATA_WIDTH-1:0] rf_rdata2,
   input  logic                  wb_we,
   input  logic [REG_ADDR_W-1:0] wb_waddr,
   input  logic [DATA_WIDTH-1:0] wb_wdata,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_op1,
   output logic [DATA_WIDTH-1:0] out_op2,
   output logic [REG_ADDR_W-1:0] out_rd,
   output logic [CTRL_WIDTH-1:0] out_ctrl
);

   fetch_entry_t                  r_a_entry;
   logic                          r_a_valid;
   logic                          r_o_valid;
   logic [DATA_WIDTH-1:0]         r_o_op1;
   logic [DATA_WIDTH-1:0]         r_o_op2;
   logic [REG_ADDR_W-1:0]         r_o_rd;
   logic [CTRL_WIDTH-1:0]         r_o_ctrl;

   logic                          w_advance;
   logic                          w_accept;
   logic                          w_stall;
   logic [1:0][REG_ADDR_W-1:0]    w_in_rs;
   logic [1:0][REG_ADDR_W-1:0]    w_a_rs;
   logic [1:0][DATA_WIDTH-1:0]    w_rf_rdata;
   logic [1:0][DATA_WIDTH-1:0]    w_resolved;

   // The register file samples these at the accept edge.
   assign rf_raddr1 = in_rs1;
   assign rf_raddr2 = in_rs2;

   assign w_advance = r_a_valid && (!r_o_valid || out_ready);
   assign w_stall   = r_a_valid && r_o_valid && !out_ready;
   assign in_ready  = !rst && !flush && (!r_a_valid || w_advance);
   assign w_accept  = in_valid && in_ready;

   assign w_in_rs    = {in_rs2, in_rs1};
   assign w_a_rs     = {r_a_entry.rs2, r_a_entry.rs1};
   assign w_rf_rdata = {rf_rdata2, rf_rdata1};

   generate
      for (genvar g = 0; g < 2; g++) begin : g_bypass
         operand_bypass #(
            .DATA_WIDTH (DATA_WIDTH),
            .ZERO_REG   (ZERO_REG)
         ) u_bypass (
            .clk      (clk),
            .rst      (rst),
            .accept   (w_accept),
            .stall    (w_stall),
            .in_rs    (w_in_rs[g]),
            .a_rs     (w_a_rs[g]),
            .wb_we    (wb_we),
            .wb_waddr (wb_waddr),
            .wb_wdata (wb_wdata),
            .rf_rdata (w_rf_rdata[g]),
            .resolved (w_resolved[g])
         );
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         r_a_valid <= 1'b0;
         r_o_valid <= 1'b0;
         r_a_entry <= '0;
         r_o_op1   <= '0;
         r_o_op2   <= '0;
         r_o_rd    <= '0;
         r_o_ctrl  <= '0;
      end else if (flush) begin
         // Entries vanish; O data is left as-is since it is no longer valid.
         r_a_valid <= 1'b0;
         r_o_valid <= 1'b0;
      end else begin
         if (w_accept) begin
            r_a_entry <= '{rs1: in_rs1, rs2: in_rs2, rd: in_rd, ctrl: in_ctrl};
         end
         r_a_valid <= w_accept || (r_a_valid && !w_advance);
         if (w_advance) begin
            r_o_valid <= 1'b1;
            r_o_op1   <= w_resolved[0];
            r_o_op2   <= w_resolved[1];
            r_o_rd    <= r_a_entry.rd;
            r_o_ctrl  <= r_a_entry.ctrl;
         end else if (out_ready) begin
            r_o_valid <= 1'b0;
         end
      end
   end

   assign out_valid = r_o_valid;
   assign out_op1   = r_o_op1;
   assign out_op2   = r_o_op2;
   assign out_rd    = r_o_rd;
   assign out_ctrl  = r_o_ctrl;

endmodule
`default_nettype wire

// File: tb/tb_operand_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_operand_fetch
// Description : Self-checking bench for operand_fetch. A behavioural register
//               file drives the read ports; a queue-based model predicts the
//               handshake and the architectural operand values each entry
//               must carry once it reaches the output register.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_operand_fetch;

   localparam int DW = 32;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          rst, flush, in_valid, in_ready;
   logic [4:0]    in_rs1, in_rs2, in_rd;
   logic [CW-1:0] in_ctrl;
   logic [4:0]    rf_raddr1, rf_raddr2;
   logic [DW-1:0] rf_rdata1, rf_rdata2;
   logic          wb_we;
   logic [4:0]    wb_waddr;
   logic [DW-1:0] wb_wdata;
   logic          out_valid, out_ready;
   logic [DW-1:0] out_op1, out_op2;
   logic [4:0]    out_rd;
   logic [CW-1:0] out_ctrl;

   always #5 clk = ~clk;

   operand_fetch #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .ZERO_REG(1'b1)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_ctrl(in_ctrl),
      .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
      .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
      .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_op1(out_op1), .out_op2(out_op2), .out_rd(out_rd), .out_ctrl(out_ctrl)
   );

   // Register file: read data returns one cycle after address sampling and
   // shows the contents from before a same-edge write.
   logic [DW-1:0] rf [32];
   always @(posedge clk) begin
      rf_rdata1 <= rf[rf_raddr1];
      rf_rdata2 <= rf[rf_raddr2];
      if (wb_we) rf[wb_waddr] <= wb_wdata;
   end

   // Reference model: architectural registers plus the ordered entries in
   // the stage. An entry's operands are the architectural values right after
   // the edge at which it enters the output register.
   typedef struct {
      logic [4:0]    rs1, rs2, rd;
      logic [CW-1:0] ctrl;
      bit            in_o;
      logic [DW-1:0] op1, op2;
   } mentry_t;

   mentry_t       q[$];
   logic [DW-1:0] arch [32];
   int            checks = 0;
   int            errors = 0;

   function automatic logic [DW-1:0] reg_val(input logic [4:0] r);
      return (r == 5'd0) ? '0 : arch[r];
   endfunction

   function automatic logic [DW-1:0] init_val(input int r);
      if (r == 3) return 32'h11;
      if (r == 4) return 32'h22;
      return 32'h1000_0000 + 32'(r);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock cycle: inputs already set at the falling edge.
   task automatic step();
      bit      exp_ready, exp_ov;
      mentry_t e;
      #1;
      exp_ready = !rst && !flush && (q.size() < 2 || out_ready);
      exp_ov    = (q.size() > 0) && q[0].in_o;
      chk("in_ready", 32'(in_ready), 32'(exp_ready));
      chk("out_valid", 32'(out_valid), 32'(exp_ov));
      if (exp_ov) begin
         chk("out_op1", out_op1, q[0].op1);
         chk("out_op2", out_op2, q[0].op2);
         chk("out_rd", 32'(out_rd), 32'(q[0].rd));
         chk("out_ctrl", 32'(out_ctrl), 32'(q[0].ctrl));
      end
      @(posedge clk);
      if (wb_we) arch[wb_waddr] = wb_wdata;
      if (rst || flush) begin
         q.delete();
      end else begin
         if (exp_ov && out_ready) void'(q.pop_front());
         if (q.size() > 0 && !q[0].in_o) begin
            e = q.pop_front();
            e.in_o = 1'b1;
            e.op1  = reg_val(e.rs1);
            e.op2  = reg_val(e.rs2);
            q.push_front(e);
         end
         if (exp_ready && in_valid) begin
            e.rs1 = in_rs1; e.rs2 = in_rs2; e.rd = in_rd; e.ctrl = in_ctrl;
            e.in_o = 1'b0; e.op1 = '0; e.op2 = '0;
            q.push_back(e);
         end
      end
      @(negedge clk);
   endtask

   typedef struct {
      logic [4:0]  rs1, rs2;
      bit          acc_we;
      logic [4:0]  acc_a;
      logic [31:0] acc_d;
      bit          a_we;
      logic [4:0]  a_a;
      logic [31:0] a_d;
      logic [31:0] e1, e2;
   } vec_t;

   vec_t vt [7];

   initial begin
      // Expected operands follow from the preload (x3=0x11, x4=0x22,
      // others 0x1000_0000+n) and the writes of earlier rows.
      vt[0] = '{5'd3, 5'd4, 1'b0, 5'd0,  32'h0,  1'b0, 5'd0, 32'h0,  32'h11,        32'h22};
      vt[1] = '{5'd5, 5'd3, 1'b1, 5'd5,  32'hAA, 1'b0, 5'd0, 32'h0,  32'hAA,        32'h11};
      vt[2] = '{5'd4, 5'd6, 1'b0, 5'd0,  32'h0,  1'b1, 5'd6, 32'hBB, 32'h22,        32'hBB};
      vt[3] = '{5'd0, 5'd5, 1'b1, 5'd0,  32'hDD, 1'b0, 5'd0, 32'h0,  32'h0,         32'hAA};
      vt[4] = '{5'd6, 5'd6, 1'b1, 5'd6,  32'h55, 1'b1, 5'd6, 32'h66, 32'h66,        32'h66};
      vt[5] = '{5'd8, 5'd0, 1'b0, 5'd0,  32'h0,  1'b1, 5'd0, 32'hEE, 32'h1000_0008, 32'h0};
      vt[6] = '{5'd9, 5'd9, 1'b1, 5'd10, 32'h77, 1'b0, 5'd0, 32'h0,  32'h1000_0009, 32'h1000_0009};

      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0;
      in_rd = '0; in_ctrl = '0; wb_we = 1'b0; wb_waddr = '0; wb_wdata = '0;
      out_ready = 1'b1;
      @(negedge clk);
      step(); step();
      #1;
      chk("rst_op1", out_op1, 32'h0);
      chk("rst_op2", out_op2, 32'h0);
      chk("rst_rd", 32'(out_rd), 32'h0);
      chk("rst_ctrl", 32'(out_ctrl), 32'h0);
      rst = 1'b0;

      for (int r = 0; r < 32; r++) begin
         wb_we = 1'b1; wb_waddr = 5'(r); wb_wdata = init_val(r);
         step();
      end
      wb_we = 1'b0;

      // Directed single-entry vectors.
      for (int i = 0; i < 7; i++) begin
         out_ready = 1'b1;
         in_valid = 1'b1; in_rs1 = vt[i].rs1; in_rs2 = vt[i].rs2;
         in_rd = 5'(i + 1); in_ctrl = 16'hC000 | 16'(i);
         wb_we = vt[i].acc_we; wb_waddr = vt[i].acc_a; wb_wdata = vt[i].acc_d;
         step();
         in_valid = 1'b0;
         wb_we = vt[i].a_we; wb_waddr = vt[i].a_a; wb_wdata = vt[i].a_d;
         step();
         wb_we = 1'b0;
         #1;
         chk("tbl_valid", 32'(out_valid), 32'h1);
         chk("tbl_op1", out_op1, vt[i].e1);
         chk("tbl_op2", out_op2, vt[i].e2);
         step();
      end

      // Stall: X sits in O, Y (rs1=7) in A while x7 is rewritten.
      out_ready = 1'b0;
      in_valid = 1'b1; in_rs1 = 5'd3; in_rs2 = 5'd4; in_rd = 5'd20; in_ctrl = 16'hAAAA;
      step();
      in_rs1 = 5'd7; in_rs2 = 5'd3; in_rd = 5'd21; in_ctrl = 16'hBBBB;
      step();
      in_rs1 = 5'd1; in_rd = 5'd22;
      for (int k = 0; k < 4; k++) begin
         wb_we = (k == 1); wb_waddr = 5'd7; wb_wdata = 32'hCC;
         #1;
         chk("stall_in_ready", 32'(in_ready), 32'h0);
         chk("stall_o_op1", out_op1, 32'h11);
         chk("stall_o_rd", 32'(out_rd), 32'd20);
         step();
      end
      wb_we = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      step();
      #1;
      chk("stall_y_rd", 32'(out_rd), 32'd21);
      chk("stall_y_op1", out_op1, 32'hCC);
      step();

      // Flush with both slots full, then an 8-entry back-to-back stream.
      out_ready = 1'b0; in_valid = 1'b1; in_rs1 = 5'd2; in_rs2 = 5'd3; in_rd = 5'd1;
      step();
      in_rd = 5'd2;
      step();
      flush = 1'b1;
      #1;
      chk("flush_in_ready", 32'(in_ready), 32'h0);
      step();
      flush = 1'b0; in_valid = 1'b0;
      #1;
      chk("flush_out_valid", 32'(out_valid), 32'h0);
      out_ready = 1'b1;
      for (int c = 0; c < 10; c++) begin
         in_valid = (c < 8);
         in_rs1 = 5'(c + 1); in_rs2 = 5'(c + 11); in_rd = 5'(c + 8); in_ctrl = 16'(c);
         #1;
         if (c >= 2) begin
            chk("stream_valid", 32'(out_valid), 32'h1);
            chk("stream_rd", 32'(out_rd), 32'(c + 6));
         end
         step();
      end
      in_valid = 1'b0;
      step();

      // Reset mid-operation, then accept on the first cycle after release.
      in_valid = 1'b1; in_rs1 = 5'd4; in_rs2 = 5'd5; in_rd = 5'd9;
      step();
      in_valid = 1'b0; rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      chk("rst_mid_valid", 32'(out_valid), 32'h0);
      chk("rst_mid_op1", out_op1, 32'h0);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step(); step(); step();

      // Randomized traffic against the model.
      for (int n = 0; n < 2000; n++) begin
         flush     = ($urandom_range(0, 99) == 0);
         in_valid  = ($urandom_range(0, 9) < 7);
         in_rs1    = 5'($urandom);
         in_rs2    = 5'($urandom);
         in_rd     = 5'($urandom);
         in_ctrl   = 16'($urandom);
         wb_we     = ($urandom_range(0, 1) == 1);
         wb_waddr  = 5'($urandom_range(0, 7));
         wb_wdata  = $urandom;
         out_ready = ($urandom_range(0, 9) < 6);
         step();
      end
      flush = 1'b0; in_valid = 1'b0; wb_we = 1'b0; out_ready = 1'b1;
      step(); step(); step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
